missionary_cannibal_checker: RTL and testbench

Consumer of the missionary/cannibal state stream: accepts one river-bank state per handshake, checks that each step is a legal crossing from the previously accepted state, and reports goal reached or the first violation. Sits downstream of the solver FSM, which produces one next state per clock. It serves as an in-system checker and as the scoreboard core for the solver bench. All state counts are people on the left (start) bank.

---
 rtl/mc_pkg.sv | 26 ++
 rtl/mc_move_legal.sv | 33 +++
 rtl/missionary_cannibal_checker.sv | 100 ++++++++++
 tb/tb_missionary_cannibal_checker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the missionary/cannibal state checker
package mc_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DONE = 2'd1,
        FAIL = 2'd2
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'b000;
    localparam logic [2:0] ERR_BAD     = 3'b001;
    localparam logic [2:0] ERR_UNSAFE  = 3'b010;
    localparam logic [2:0] ERR_OVERRUN = 3'b011;
    localparam logic [2:0] ERR_LOOP    = 3'b100;

    localparam logic [1:0] START_M = 2'd3;
    localparam logic [1:0] START_C = 2'd3;
    localparam logic [1:0] GOAL_M  = 2'd0;
    localparam logic [1:0] GOAL_C  = 2'd0;

    // Visited-bitmap index of a position: {boat side, missionaries, cannibals}
    function automatic logic [4:0] mc_idx(input logic side, input logic [1:0] m, input logic [1:0] c);
        return {side, m, c};
    endfunction

endpackage

// File: rtl/mc_move_legal.sv
// mc_move_legal: combinational crossing legality and bank safety check
module mc_move_legal (
    input  logic       side,
    input  logic [1:0] cur_m,
    input  logic [1:0] cur_c,
    input  logic [1:0] new_m,
    input  logic [1:0] new_c,
    output logic       bad_move,
    output logic       unsafe
);

    logic [2:0] cm, cc, nm, nc, dm, dc, sum, rm, rc;
    logic       dir_ok, left_ok, right_ok;

    // Boat on the left removes people from the left bank, on the right it brings them back
    always_comb begin
        cm       = {1'b0, cur_m};
        cc       = {1'b0, cur_c};
        nm       = {1'b0, new_m};
        nc       = {1'b0, new_c};
        dir_ok   = side ? (nm <= cm && nc <= cc) : (nm >= cm && nc >= cc);
        dm       = side ? cm - nm : nm - cm;
        dc       = side ? cc - nc : nc - cc;
        sum      = dm + dc;
        bad_move = !dir_ok || !(sum == 3'd1 || sum == 3'd2);
        rm       = 3'd3 - nm;
        rc       = 3'd3 - nc;
        left_ok  = nm == 3'd0 || nm >= nc;
        right_ok = rm == 3'd0 || rm >= rc;
        unsafe   = !(left_ok && right_ok);
    end

endmodule

// File: rtl/missionary_cannibal_checker.sv
// missionary_cannibal_checker: validates a stream of river-bank states; MC_CHECKER_LOOP_DET_EN adds revisit detection
module missionary_cannibal_checker
    import mc_pkg::*;
#(
    parameter int MAX_MOVES = 15,
    parameter int MOVE_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_missionary,
    input  logic [1:0]        in_cannibal,
    output logic              boat_side,
    output logic [MOVE_W-1:0] move_count,
    output logic              goal,
    output logic              error,
    output logic [2:0]        err_code
);

    localparam logic [MOVE_W:0] MAX_L = (MOVE_W + 1)'(MAX_MOVES);

    state_t        state;
    logic [1:0]    cur_m, cur_c;
    logic          fire, bad_move, unsafe, overrun, loop_hit, at_goal;
    logic [MOVE_W:0] next_count;
    logic [2:0]    chk_code;

    mc_move_legal u_legal (
        .side    (boat_side),
        .cur_m   (cur_m),
        .cur_c   (cur_c),
        .new_m   (in_missionary),
        .new_c   (in_cannibal),
        .bad_move(bad_move),
        .unsafe  (unsafe)
    );

`ifdef MC_CHECKER_LOOP_DET_EN
    logic [31:0] visited;
    logic [4:0]  new_idx;

    // Remember every position (including the start) that the run has stood on
    always_ff @(posedge clk) begin
        if (!reset)
            visited <= 32'd1 << mc_idx(1'b1, START_M, START_C);
        else if (fire && chk_code == ERR_NONE)
            visited[new_idx] <= 1'b1;
    end

    assign new_idx  = mc_idx(~boat_side, in_missionary, in_cannibal);
    assign loop_hit = visited[new_idx];
`else
    assign loop_hit = 1'b0;
`endif

    assign in_ready   = state == RUN;
    assign fire       = in_valid && in_ready;
    assign next_count = {1'b0, move_count} + (MOVE_W + 1)'(1);
    assign overrun    = next_count > MAX_L;
    assign at_goal    = boat_side && in_missionary == GOAL_M && in_cannibal == GOAL_C;

    // First failing check wins: bad move, then unsafe, then loop, then overrun
    always_comb begin
        chk_code = bad_move ? ERR_BAD :
                   unsafe   ? ERR_UNSAFE :
                   loop_hit ? ERR_LOOP :
                   overrun  ? ERR_OVERRUN : ERR_NONE;
    end

    // Run FSM: accept legal crossings, stop on goal or on the first violation
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= RUN;
            cur_m      <= START_M;
            cur_c      <= START_C;
            boat_side  <= 1'b1;
            move_count <= '0;
            goal       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
        end else if (fire) begin
            if (chk_code != ERR_NONE) begin
                state    <= FAIL;
                error    <= 1'b1;
                err_code <= chk_code;
            end else begin
                cur_m      <= in_missionary;
                cur_c      <= in_cannibal;
                boat_side  <= ~boat_side;
                move_count <= next_count[MOVE_W-1:0];
                if (at_goal) begin
                    state <= DONE;
                    goal  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_missionary_cannibal_checker.sv
// tb_missionary_cannibal_checker: table, directed and random checks of the state checker
module tb_missionary_cannibal_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_m = 2'd0, in_c = 2'd0;
    logic       ready0, side0, goal0, err0;
    logic [3:0] cnt0;
    logic [2:0] code0;
    logic       ready1, side1, goal1, err1;
    logic [2:0] cnt1;
    logic [2:0] code1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    missionary_cannibal_checker dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready0),
        .in_missionary(in_m), .in_cannibal(in_c), .boat_side(side0),
        .move_count(cnt0), .goal(goal0), .error(err0), .err_code(code0)
    );

    missionary_cannibal_checker #(.MAX_MOVES(4), .MOVE_W(3)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready1),
        .in_missionary(in_m), .in_cannibal(in_c), .boat_side(side1),
        .move_count(cnt1), .goal(goal1), .error(err1), .err_code(code1)
    );

    // Reference model: people counts on the left bank, one copy per DUT
    int maxm[2] = '{15, 4};
    int mm[2], mc[2], ms[2], cnt[2], g[2], e[2], code[2];
    bit vis[2][4][4][2];

    function automatic bit legal_move(int cm, int cc, int side, int nm, int nc);
        int dm = side ? cm - nm : nm - cm;
        int dc = side ? cc - nc : nc - cc;
        return dm >= 0 && dc >= 0 && dm + dc >= 1 && dm + dc <= 2;
    endfunction

    function automatic bit safe(int nm, int nc);
        return (nm == 0 || nm >= nc) && (nm == 3 || (3 - nm) >= (3 - nc));
    endfunction

    task automatic model_step(bit r, bit v, int nm, int nc);
        for (int i = 0; i < 2; i++) begin
            if (!r) begin
                mm[i] = 3; mc[i] = 3; ms[i] = 1; cnt[i] = 0; g[i] = 0; e[i] = 0; code[i] = 0;
                for (int a = 0; a < 4; a++)
                    for (int b = 0; b < 4; b++)
                        for (int s = 0; s < 2; s++)
                            vis[i][a][b][s] = 0;
                vis[i][3][3][1] = 1;
            end else if (v && !g[i] && !e[i]) begin
                bit bad = !legal_move(mm[i], mc[i], ms[i], nm, nc);
                bit uns = !safe(nm, nc);
                bit lp = 0;
                bit ov = cnt[i] + 1 > maxm[i];
`ifdef MC_CHECKER_LOOP_DET_EN
                lp = vis[i][nm][nc][1 - ms[i]];
`endif
                code[i] = bad ? 1 : uns ? 2 : lp ? 4 : ov ? 3 : 0;
                if (code[i] != 0) e[i] = 1;
                else begin
                    mm[i] = nm; mc[i] = nc; ms[i] = 1 - ms[i]; cnt[i]++;
                    vis[i][nm][nc][ms[i]] = 1;
                    if (nm == 0 && nc == 0 && ms[i] == 0) g[i] = 1;
                end
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk0(string name, bit rdy, bit sd, int ct, bit gl, bit er, int cd);
        chk({name, ".ready"}, 32'(ready0), 32'(rdy));
        chk({name, ".side"}, 32'(side0), 32'(sd));
        chk({name, ".count"}, 32'(cnt0), 32'(ct));
        chk({name, ".goal"}, 32'(goal0), 32'(gl));
        chk({name, ".error"}, 32'(err0), 32'(er));
        chk({name, ".code"}, 32'(code0), 32'(cd));
    endtask

    task automatic step(bit r, bit v, int m, int c);
        @(negedge clk);
        reset = r; in_valid = v; in_m = 2'(m); in_c = 2'(c);
        @(posedge clk);
        model_step(r, v, m, c);
        #1;
    endtask

    typedef struct {
        bit r, v;
        int m, c;
        bit e_ready, e_side;
        int e_cnt;
        bit e_goal, e_err;
        int e_code;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit v, int m, int c, bit rdy, bit sd, int ct, bit gl, bit er, int cd);
        vec_t t;
        t.r = r; t.v = v; t.m = m; t.c = c; t.e_ready = rdy; t.e_side = sd;
        t.e_cnt = ct; t.e_goal = gl; t.e_err = er; t.e_code = cd;
        return t;
    endfunction

    int sol_m[11] = '{3, 3, 3, 3, 1, 2, 0, 0, 0, 0, 0};
    int sol_c[11] = '{1, 2, 0, 1, 1, 2, 2, 3, 1, 2, 0};

    task automatic run_solution(bit gaps);
        for (int k = 0; k < 11; k++) begin
            if (gaps) begin
                step(1, 0, $urandom_range(3), $urandom_range(3));
                chk("gap.count", 32'(cnt0), 32'(k));
            end
            step(1, 1, sol_m[k], sol_c[k]);
        end
        chk0("solution", 0, 0, 11, 1, 0, 0);
    endtask

    initial begin
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        for (int k = 0; k < 11; k++)
            tbl.push_back(mk(1, 1, sol_m[k], sol_c[k], k != 10, k % 2 == 1, k + 1, k == 10, 0, 0));
        tbl.push_back(mk(1, 1, 3, 3, 0, 0, 11, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 3, 0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 3, 1, 0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 3, 0, 1, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 3, 3, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 2, 1, 0, 1, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].m, tbl[i].c);
            chk0($sformatf("tbl%0d", i), tbl[i].e_ready, tbl[i].e_side, tbl[i].e_cnt,
                 tbl[i].e_goal, tbl[i].e_err, tbl[i].e_code);
        end

        // Reset mid-run wins over a simultaneous valid, then the full solution passes again
        step(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 1, sol_m[k], sol_c[k]);
        chk("midrun.count_before", 32'(cnt0), 32'd3);
        step(0, 1, 3, 1);
        chk0("midrun.reset", 1, 1, 0, 0, 0, 0);
        run_solution(0);

        // Idle gaps between moves leave the final result unchanged
        step(0, 0, 0, 0);
        run_solution(1);

        // Shuttling: overrun at the fifth state on the MAX_MOVES=4 instance, or loop at the second
        step(0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 3, k % 2 == 0 ? 1 : 3);
`ifdef MC_CHECKER_LOOP_DET_EN
            if (k == 1) begin
                chk("loop.code1", 32'(code1), 32'd4);
                chk("loop.count1", 32'(cnt1), 32'd1);
                chk("loop.code0", 32'(code0), 32'd4);
            end
`else
            if (k == 3) chk("shuttle.err1_before", 32'(err1), 32'd0);
`endif
        end
`ifndef MC_CHECKER_LOOP_DET_EN
        chk("overrun.code1", 32'(code1), 32'd3);
        chk("overrun.count1", 32'(cnt1), 32'd4);
        chk("overrun.ready1", 32'(ready1), 32'd0);
        chk("overrun.count0", 32'(cnt0), 32'd5);
        chk("overrun.err0", 32'(err0), 32'd0);
`endif

        // Random walk biased toward legal crossings, compared with the model every cycle
        step(0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            int cm[$], cc[$];
            int nm, nc, pick;
            bit r, v;
            for (int a = 0; a < 4; a++)
                for (int b = 0; b < 4; b++)
                    if (legal_move(mm[0], mc[0], ms[0], a, b) && safe(a, b)) begin
                        cm.push_back(a); cc.push_back(b);
                    end
            if (cm.size() != 0 && $urandom_range(9) < 7) begin
                pick = $urandom_range(cm.size() - 1);
                nm = cm[pick]; nc = cc[pick];
            end else begin
                nm = $urandom_range(3); nc = $urandom_range(3);
            end
            r = !(((g[0] || e[0]) && $urandom_range(2) == 0) || $urandom_range(63) == 0);
            v = $urandom_range(9) < 8;
            step(r, v, nm, nc);
            chk("rnd.ready0", 32'(ready0), 32'(!(g[0] || e[0])));
            chk("rnd.side0", 32'(side0), 32'(ms[0]));
            chk("rnd.count0", 32'(cnt0), 32'(cnt[0]));
            chk("rnd.goal0", 32'(goal0), 32'(g[0]));
            chk("rnd.error0", 32'(err0), 32'(e[0]));
            chk("rnd.code0", 32'(code0), 32'(code[0]));
            chk("rnd.ready1", 32'(ready1), 32'(!(g[1] || e[1])));
            chk("rnd.side1", 32'(side1), 32'(ms[1]));
            chk("rnd.count1", 32'(cnt1), 32'(cnt[1]));
            chk("rnd.goal1", 32'(goal1), 32'(g[1]));
            chk("rnd.error1", 32'(err1), 32'(e[1]));
            chk("rnd.code1", 32'(code1), 32'(code[1]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
